cpu_control_pipe: RTL

- Pipelined successor to the single-cycle control decoder.
- Decodes the ID-stage opcode into the control bundle and registers it into the ID/EX control register.
- Detects load-use hazards and inserts bubbles; handles flush, external hold, illegal opcodes and a sticky halt.
- Sits between the IF/ID register and the EX stage; drives the PC/IF-ID freeze.

---
 rtl/cpu_ctl_pkg.sv | 38 +++
 rtl/cpu_ctl_decode.sv | 109 ++++++++++
 rtl/cpu_control_pipe.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctl_pkg.sv
// cpu_ctl_pkg: shared definitions for the pipelined control decoder.
//   - opcode constants for the non-ALU instruction classes
//   - ALU op codes and MemtoReg writeback encodings
//   - bit positions of the 7-bit control bundle {RR MR MW AS RW PS PW}
package cpu_ctl_pkg;

    typedef enum logic [3:0] {
        OP_LW  = 4'b1000,
        OP_SW  = 4'b1001,
        OP_LLB = 4'b1010,
        OP_LHB = 4'b1011,
        OP_B   = 4'b1100,
        OP_BR  = 4'b1101,
        OP_PCS = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    // Opcodes 0000-0111 pass their low three bits straight through as the ALU op.
    localparam logic [2:0] ALU_ADD = 3'b000;  // address generation for LW/SW
    localparam logic [2:0] ALU_CTL = 3'b010;  // immediate, branch, PC and halt ops

    typedef enum logic [1:0] {
        M2R_NONE = 2'b00,
        M2R_IMM  = 2'b01,
        M2R_ALU  = 2'b10,
        M2R_MEM  = 2'b11
    } memtoreg_e;

    localparam int unsigned CB_W  = 7;
    localparam int unsigned CB_RR = 6;  // reg read
    localparam int unsigned CB_MR = 5;  // mem read
    localparam int unsigned CB_MW = 4;  // mem write
    localparam int unsigned CB_AS = 3;  // alu src
    localparam int unsigned CB_RW = 2;  // reg write
    localparam int unsigned CB_PS = 1;  // pc source
    localparam int unsigned CB_PW = 0;  // pc write

endpackage

// File: rtl/cpu_ctl_decode.sv
// cpu_ctl_decode: purely combinational opcode decoder.
// Ports:
//   opcode          in   OPCODE_W    instruction opcode
//   rd, rs, rt      in   REG_ADDR_W  register fields
//   ctl             out  CB_W        control bundle {RR MR MW AS RW PS PW}
//   alu_op          out  3           ALU op
//   mem_to_reg      out  2           writeback select
//   halt, illegal   out  1           HLT / illegal-opcode flags
//   src1_en, src1   out  1/REG_ADDR_W first source register used for hazards
//   src2_en, src2   out  1/REG_ADDR_W second source register used for hazards
module cpu_ctl_decode
    import cpu_ctl_pkg::*;
#(
    parameter int unsigned OPCODE_W   = 4,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic [CB_W-1:0]       ctl,
    output logic [2:0]            alu_op,
    output logic [1:0]            mem_to_reg,
    output logic                  halt,
    output logic                  illegal,
    output logic                  src1_en,
    output logic [REG_ADDR_W-1:0] src1,
    output logic                  src2_en,
    output logic [REG_ADDR_W-1:0] src2
);

    logic [3:0] op4;
    logic       upper_set;

    assign op4 = opcode[3:0];

    // Any opcode bit above bit 3 marks the instruction illegal.
    always_comb begin
        upper_set = 1'b0;
        for (int unsigned i = 4; i < OPCODE_W; i++) begin
            if (opcode[i]) upper_set = 1'b1;
        end
    end

    always_comb begin
        ctl        = '0;
        alu_op     = ALU_ADD;
        mem_to_reg = M2R_NONE;
        halt       = 1'b0;
        illegal    = 1'b0;
        src1_en    = 1'b0;
        src1       = rs;
        src2_en    = 1'b0;
        src2       = rt;
        if (upper_set) begin
            illegal = 1'b1;
        end else if (!op4[3]) begin
            ctl[CB_RR] = 1'b1;
            ctl[CB_RW] = 1'b1;
            alu_op     = op4[2:0];
            mem_to_reg = M2R_ALU;
            src1_en    = 1'b1;
            // 0100-0110 are immediate forms and do not read rt.
            src2_en    = !op4[2] || (op4[2:0] == 3'b111);
        end else begin
            case (op4)
                OP_LW: begin
                    ctl[CB_RR] = 1'b1; ctl[CB_MR] = 1'b1;
                    ctl[CB_AS] = 1'b1; ctl[CB_RW] = 1'b1;
                    mem_to_reg = M2R_MEM;
                    src1_en    = 1'b1;
                end
                OP_SW: begin
                    ctl[CB_RR] = 1'b1; ctl[CB_MW] = 1'b1;
                    ctl[CB_AS] = 1'b1; ctl[CB_RW] = 1'b1;
                    src1_en    = 1'b1;
                    src2_en    = 1'b1;
                end
                OP_LLB, OP_LHB: begin
                    ctl[CB_AS] = 1'b1; ctl[CB_RW] = 1'b1;
                    alu_op     = ALU_CTL;
                    mem_to_reg = M2R_IMM;
                    // Byte loads merge into rd, so rd is also a source.
                    src1       = rd;
                    src1_en    = 1'b1;
                end
                OP_B: begin
                    ctl[CB_AS] = 1'b1; ctl[CB_PS] = 1'b1;
                    alu_op     = ALU_CTL;
                end
                OP_BR: begin
                    ctl[CB_RR] = 1'b1; ctl[CB_PS] = 1'b1;
                    alu_op     = ALU_CTL;
                    src1_en    = 1'b1;
                end
                OP_PCS: begin
                    ctl[CB_RW] = 1'b1; ctl[CB_PW] = 1'b1;
                    alu_op     = ALU_CTL;
                end
                OP_HLT: begin
                    alu_op = ALU_CTL;
                    halt   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_control_pipe.sv
// cpu_control_pipe: decodes the ID-stage opcode and registers the control
// bundle into the ID/EX register; inserts load-use bubbles, honours flush,
// external hold and a sticky halt.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_valid_i, id_opcode_i       ID instruction valid / opcode
//   id_rd_i, id_rs_i, id_rt_i     ID register fields
//   hold_i                        downstream busy: freeze ID/EX and front end
//   flush_i                       branch redirect: kill ID instruction
//   stall_o                       freeze PC and IF/ID (combinational)
//   ex_*_o                        registered ID/EX control and destination
//   halted_o                      sticky halt, cleared only by rst
module cpu_control_pipe
    import cpu_ctl_pkg::*;
#(
    parameter int unsigned OPCODE_W           = 4,
    parameter int unsigned REG_ADDR_W         = 4,
    parameter int unsigned ALUOP_W            = 3,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [OPCODE_W-1:0]   id_opcode_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  hold_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ex_valid_o,
    output logic                  ex_reg_read_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o,
    output logic                  ex_alu_src_o,
    output logic                  ex_reg_write_o,
    output logic                  ex_pc_source_o,
    output logic                  ex_pcw_o,
    output logic                  ex_halt_o,
    output logic [ALUOP_W-1:0]    ex_alu_op_o,
    output logic [1:0]            ex_mem_to_reg_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic                  ex_illegal_o,
    output logic                  halted_o
);

    logic [CB_W-1:0]       dec_ctl;
    logic [2:0]            dec_alu;
    logic [1:0]            dec_m2r;
    logic                  dec_halt;
    logic                  dec_illegal;
    logic                  dec_src1_en;
    logic [REG_ADDR_W-1:0] dec_src1;
    logic                  dec_src2_en;
    logic [REG_ADDR_W-1:0] dec_src2;

    cpu_ctl_decode #(
        .OPCODE_W   (OPCODE_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decode (
        .opcode     (id_opcode_i),
        .rd         (id_rd_i),
        .rs         (id_rs_i),
        .rt         (id_rt_i),
        .ctl        (dec_ctl),
        .alu_op     (dec_alu),
        .mem_to_reg (dec_m2r),
        .halt       (dec_halt),
        .illegal    (dec_illegal),
        .src1_en    (dec_src1_en),
        .src1       (dec_src1),
        .src2_en    (dec_src2_en),
        .src2       (dec_src2)
    );

    logic                  lu;
    logic                  capture;
    logic [CB_W-1:0]       nxt_ctl;
    logic [ALUOP_W-1:0]    nxt_alu;
    logic [1:0]            nxt_m2r;
    logic [REG_ADDR_W-1:0] nxt_rd;
    logic                  nxt_halt;
    logic                  nxt_illegal;

    always_comb begin
        lu = id_valid_i && ex_valid_o && ex_mem_read_o &&
             ((dec_src1_en && (dec_src1 == ex_rd_o)) ||
              (dec_src2_en && (dec_src2 == ex_rd_o))) &&
             !(ZERO_REG_HARDWIRED && (ex_rd_o == '0));
    end

    // Priority below rst: hold, flush, halted, load-use, normal issue.
    always_comb begin
        stall_o = 1'b0;
        if (rst)           stall_o = 1'b0;
        else if (hold_i)   stall_o = 1'b1;
        else if (flush_i)  stall_o = 1'b0;
        else if (halted_o) stall_o = 1'b1;
        else               stall_o = lu;
    end

    // Anything that is not a capture loads a bubble with every field cleared.
    always_comb begin
        capture     = id_valid_i && !flush_i && !halted_o && !lu;
        nxt_ctl     = '0;
        nxt_alu     = '0;
        nxt_m2r     = '0;
        nxt_rd      = '0;
        nxt_halt    = 1'b0;
        nxt_illegal = 1'b0;
        if (capture) begin
            nxt_ctl     = dec_ctl;
            nxt_alu     = ALUOP_W'(dec_alu);
            nxt_m2r     = dec_m2r;
            nxt_rd      = id_rd_i;
            nxt_halt    = dec_halt;
            nxt_illegal = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_o      <= 1'b0;
            ex_reg_read_o   <= 1'b0;
            ex_mem_read_o   <= 1'b0;
            ex_mem_write_o  <= 1'b0;
            ex_alu_src_o    <= 1'b0;
            ex_reg_write_o  <= 1'b0;
            ex_pc_source_o  <= 1'b0;
            ex_pcw_o        <= 1'b0;
            ex_halt_o       <= 1'b0;
            ex_alu_op_o     <= '0;
            ex_mem_to_reg_o <= '0;
            ex_rd_o         <= '0;
            ex_illegal_o    <= 1'b0;
            halted_o        <= 1'b0;
        end else if (!hold_i) begin
            ex_valid_o      <= capture;
            ex_reg_read_o   <= nxt_ctl[CB_RR];
            ex_mem_read_o   <= nxt_ctl[CB_MR];
            ex_mem_write_o  <= nxt_ctl[CB_MW];
            ex_alu_src_o    <= nxt_ctl[CB_AS];
            ex_reg_write_o  <= nxt_ctl[CB_RW];
            ex_pc_source_o  <= nxt_ctl[CB_PS];
            ex_pcw_o        <= nxt_ctl[CB_PW];
            ex_halt_o       <= nxt_halt;
            ex_alu_op_o     <= nxt_alu;
            ex_mem_to_reg_o <= nxt_m2r;
            ex_rd_o         <= nxt_rd;
            ex_illegal_o    <= nxt_illegal;
            if (nxt_halt) halted_o <= 1'b1;
        end
    end

endmodule
